gb_link_peer: RTL and testbench
===============================

Name: gb_link_peer

Overview:
Emulates the remote Game Boy at the far end of the serial link cable, so a host such as the HPS bridge can exchange bytes with the core's serial port.
- Slave mode: follows the core's internally generated 8192 Hz shift clock.
- Master mode: generates the shift clock for a core that is set to external clock.
- Host side: a one-entry transmit holding register and a one-cycle receive strobe.

Parameters:
- CLK_DIV, 511: bit period minus 1, in clk cycles, for master mode; bit period = CLK_DIV+1 cycles.
- TIMEOUT_CYCLES, 65535: slave-mode inactivity limit; used only with LINK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- master_mode  in  1  1 = peer drives the shift clock; sampled only while idle
- start  in  1  master mode: start a transfer; ignored when busy or in slave mode
- tx_data  in  8  next byte to send
- tx_valid  in  1  write tx_data into the holding register
- tx_ready  out  1  holding register empty
- rx_data  out  8  last completed received byte
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  transfer in progress
- timeout_err  out  1  one-cycle pulse on slave abort
- serial_clk_in  in  1  shift clock from the core
- serial_data_in  in  1  serial data from the core
- serial_clk_out  out  1  shift clock to the core; idles high
- serial_data_out  out  1  serial data to the core

Behaviour:
- Reset (asynchronous): all registers clear immediately, mid-transfer included. Output values:
  - serial_clk_out=1, serial_data_out=1
  - rx_data=0x00, rx_valid=0
  - busy=0, tx_ready=1, timeout_err=0
  - bit counter=0, holding register empty
- Input synchronisers: serial_clk_in and serial_data_in each pass through 2 flops, giving equal latency. Edges are detected on the synchronised clock against its previous value.
- Holding register:
  - tx_valid && tx_ready loads the holding register; tx_ready drops the next cycle.
  - tx_valid while the register is full is ignored.
- Byte load: occurs at the start of each byte.
  - shift <= holding register if full, else 0xFF (the open-line value); the holding register then empties.
  - If tx_valid coincides with a load, the load uses the old holding state and the new byte is kept for the next transfer.
- Bit order: MSB first.
  - Falling edge of the shift clock: drive serial_data_out <= shift[7].
  - Rising edge: shift <= {shift[6:0], data_in_sync}.
- States: IDLE, SLAVE_XFER, MASTER_LOW, MASTER_HIGH.
- IDLE:
  - Synchronised falling edge with master_mode=0: byte load, drive bit 7, bit counter=8, busy=1, go to SLAVE_XFER.
  - start with master_mode=1: byte load, serial_clk_out<=0, serial_data_out<=new shift[7], div=CLK_DIV, bit counter=8, busy=1, go to MASTER_LOW.
  - If a falling edge and start occur together, master_mode selects the branch.
- SLAVE_XFER:
  - Each rising edge shifts in one bit and decrements the counter.
  - Each falling edge drives shift[7].
  - When the counter reaches 0 on a rising edge: rx_data<=shifted value, rx_valid pulses the next cycle, busy=0, go to IDLE.
- MASTER_LOW / MASTER_HIGH: div decrements every cycle.
  - When div==(CLK_DIV+1)/2 (in MASTER_LOW): serial_clk_out<=1, shift in, decrement the counter, go to MASTER_HIGH.
  - When div==0 (in MASTER_HIGH):
    - If the counter != 0: serial_clk_out<=0, drive shift[7], div<=CLK_DIV, go to MASTER_LOW.
    - Else: rx_data/rx_valid update, busy=0, serial_clk_out stays 1, go to IDLE.
- master_mode changes during a transfer are ignored.
- serial_data_out holds its last bit while idle.

Optional Feature:
LINK_TIMEOUT_EN.
- Defined: in SLAVE_XFER, a counter clears on every synchronised clock edge. When it reaches TIMEOUT_CYCLES:
  - abort the transfer: go to IDLE, busy=0, bit counter=0
  - pulse timeout_err
  - no rx_valid; the holding register stays empty
- Undefined: the counter is absent, timeout_err is tied to 0, and a partial slave transfer waits indefinitely.

Test Plan:
- Slave, tx 0x5A queued; bench clocks 8 bits while driving 0xC3 -> serial_data_out on falling edges reads 0,1,0,1,1,0,1,0; rx_data=0xC3; exactly one rx_valid; tx_ready=1 after the first edge.
- Slave, no byte queued; 8 clocks with data 0x00 -> serial_data_out all 1 (0xFF); rx_data=0x00.
- Master, CLK_DIV=15, tx 0x81, serial_data_out looped to serial_data_in, pulse start -> 8 low pulses of 8 cycles each, high phases of 8 cycles each; rx_data=0x81; busy for 128 cycles.
- tx_valid=0x33 in the same cycle as a byte load with the register empty -> current byte 0xFF, next transfer sends 0x33.
- rst asserted after 3 bits of a master transfer -> immediately serial_clk_out=1, busy=0, no rx_valid; the next start transfers cleanly.
- LINK_TIMEOUT_EN with TIMEOUT_CYCLES=100; stop the clock after 4 bits -> timeout_err pulses once, 100 cycles after the last edge; busy=0; no rx_valid.

Source files
------------

// File: rtl/gb_link_peer.sv
// Game Boy link-cable peer: slave follows the core's shift clock, master generates it.
// Optional slave inactivity abort is built when LINK_TIMEOUT_EN is defined.
module gb_link_peer #(
  parameter int CLK_DIV        = 511,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       master_mode,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       timeout_err,
  input  logic       serial_clk_in,
  input  logic       serial_data_in,
  output logic       serial_clk_out,
  output logic       serial_data_out
);

  localparam int DW = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam logic [DW-1:0] DIV_FULL = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_HALF = DW'((CLK_DIV + 1) / 2);

  typedef enum logic [1:0] {IDLE, SLAVE_XFER, MASTER_LOW, MASTER_HIGH} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic [7:0]    shift;
  logic [7:0]    hold_data;
  logic [3:0]    bit_cnt;
  logic [DW-1:0] div;

  logic       clk_fall;
  logic       clk_rise;
  logic [7:0] load_byte;
  logic [7:0] shift_in;

  assign clk_fall  = clk_prev & ~clk_sync[1];
  assign clk_rise  = ~clk_prev & clk_sync[1];
  // An empty holding register sends the open-line value.
  assign load_byte = tx_ready ? 8'hFF : hold_data;
  assign shift_in  = {shift[6:0], data_sync[1]};

`ifdef LINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      clk_sync        <= '0;
      data_sync       <= '0;
      clk_prev        <= 1'b0;
      shift           <= '0;
      hold_data       <= '0;
      tx_ready        <= 1'b1;
      bit_cnt         <= '0;
      div             <= '0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      busy            <= 1'b0;
      serial_clk_out  <= 1'b1;
      serial_data_out <= 1'b1;
`ifdef LINK_TIMEOUT_EN
      to_cnt          <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      clk_sync  <= {clk_sync[0], serial_clk_in};
      data_sync <= {data_sync[0], serial_data_in};
      clk_prev  <= clk_sync[1];
      rx_valid  <= 1'b0;
`ifdef LINK_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif

      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if ((!master_mode && clk_fall) || (master_mode && start)) begin
            shift           <= load_byte;
            serial_data_out <= load_byte[7];
            // A full register empties here; a coincident tx_valid only lands when it was empty.
            if (!tx_ready) tx_ready <= 1'b1;
            bit_cnt         <= 4'd8;
            busy            <= 1'b1;
            if (master_mode) begin
              serial_clk_out <= 1'b0;
              div            <= DIV_FULL;
              state          <= MASTER_LOW;
            end else begin
`ifdef LINK_TIMEOUT_EN
              to_cnt <= '0;
`endif
              state  <= SLAVE_XFER;
            end
          end
        end

        SLAVE_XFER: begin
          if (clk_rise) begin
            shift   <= shift_in;
            bit_cnt <= bit_cnt - 4'd1;
            if (bit_cnt == 4'd1) begin
              rx_data  <= shift_in;
              rx_valid <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else if (clk_fall) begin
            serial_data_out <= shift[7];
          end
`ifdef LINK_TIMEOUT_EN
          if (clk_rise || clk_fall) begin
            to_cnt <= '0;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            bit_cnt     <= '0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end

        MASTER_LOW: begin
          div <= div - 1'b1;
          if (div == DIV_HALF) begin
            serial_clk_out <= 1'b1;
            shift          <= shift_in;
            bit_cnt        <= bit_cnt - 4'd1;
            state          <= MASTER_HIGH;
          end
        end

        MASTER_HIGH: begin
          if (div != '0) begin
            div <= div - 1'b1;
          end else if (bit_cnt != 4'd0) begin
            serial_clk_out  <= 1'b0;
            serial_data_out <= shift[7];
            div             <= DIV_FULL;
            state           <= MASTER_LOW;
          end else begin
            rx_data  <= shift;
            rx_valid <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_link_peer.sv
// Self-checking bench for gb_link_peer: vector table for whole transfers, scoreboard on rx_valid,
// hand-written sequences for coincident load, mid-transfer reset and slave stall.
module tb_gb_link_peer;

  localparam int CLK_DIV = 15;
  localparam int HALF    = (CLK_DIV + 1) / 2;
  localparam int TO      = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       master_mode = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       timeout_err;
  logic       sclk_in = 1'b1;
  logic       sdi_drv = 1'b1;
  logic       loop = 1'b0;
  logic       serial_data_in;
  logic       serial_clk_out;
  logic       serial_data_out;

  assign serial_data_in = loop ? serial_data_out : sdi_drv;

  gb_link_peer #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .master_mode     (master_mode),
    .start           (start),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .serial_clk_in   (sclk_in),
    .serial_data_in  (serial_data_in),
    .serial_clk_out  (serial_clk_out),
    .serial_data_out (serial_data_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int rx_count = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rx_valid pulse pops the byte pushed when its transfer was started.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_count++;
      if (sb_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else check("rx_data", {24'd0, rx_data}, {24'd0, sb_q.pop_front()});
    end
  end

  typedef struct {
    logic       master;
    logic       queue;
    logic [7:0] tx;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vec[6];

  task automatic queue_tx(input logic [7:0] b);
    @(posedge clk); #1 tx_valid = 1'b1; tx_data = b;
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic slave_bits(input logic [7:0] din, input int nbits,
                            output logic [7:0] bits, output logic ready_first);
    bits = '0;
    ready_first = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 sclk_in = 1'b0; sdi_drv = din[7-i];
      repeat (6) @(negedge clk);
      bits = {bits[6:0], serial_data_out};
      if (i == 0) ready_first = tx_ready;
      @(posedge clk); #1 sclk_in = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic master_xfer(input logic with_tx, input logic [7:0] tx_b,
                             output logic [7:0] bits, output int busy_cyc,
                             output int low_pulses, output int bad_phases);
    int low_run, high_run;
    logic prev_sclk;
    logic seen_busy;
    logic done;
    bits = '0; busy_cyc = 0; low_pulses = 0; bad_phases = 0;
    low_run = 0; high_run = 0; prev_sclk = 1'b1; seen_busy = 1'b0; done = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    if (with_tx) begin tx_valid = 1'b1; tx_data = tx_b; end
    @(posedge clk); #1 start = 1'b0; tx_valid = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        seen_busy = 1'b1;
        busy_cyc++;
        if (!serial_clk_out) low_run++;
        else high_run++;
        if (prev_sclk && !serial_clk_out) begin
          low_pulses++;
          if (low_pulses > 1 && high_run != HALF) bad_phases++;
          high_run = 0;
        end
        if (!prev_sclk && serial_clk_out) begin
          bits = {bits[6:0], serial_data_out};
          if (low_run != HALF) bad_phases++;
          low_run = 0;
        end
        prev_sclk = serial_clk_out;
      end else if (seen_busy) begin
        done = 1'b1;
      end
    end
    if (!done) check("master_timeout", 32'd0, 32'd1);
    if (high_run != HALF) bad_phases++;
  endtask

  task automatic run_master(input string tag, input logic with_tx, input logic [7:0] tx_b,
                            input logic [7:0] exp_out);
    logic [7:0] bits;
    int bc, lp, bad;
    master_xfer(with_tx, tx_b, bits, bc, lp, bad);
    check({tag, "_out_bits"}, {24'd0, bits}, {24'd0, exp_out});
    check({tag, "_busy_cycles"}, bc, 8 * (CLK_DIV + 1));
    check({tag, "_low_pulses"}, lp, 32'd8);
    check({tag, "_phase_len"}, bad, 32'd0);
    check({tag, "_sclk_idle"}, {31'd0, serial_clk_out}, 32'd1);
  endtask

  initial begin
    logic [7:0] bits;
    logic rdy;
    int pulses, first, cnt;

    vec[0] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vec[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
    vec[2] = '{1'b1, 1'b1, 8'h81, 8'h00, 8'h81, 8'h81};
    vec[3] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF};
    vec[4] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vec[5] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_sclk_out", {31'd0, serial_clk_out}, 32'd1);
    check("rst_sdata_out", {31'd0, serial_data_out}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    foreach (vec[i]) begin
      #1 master_mode = vec[i].master; loop = vec[i].master;
      if (vec[i].queue) queue_tx(vec[i].tx);
      sb_q.push_back(vec[i].exp_rx);
      if (vec[i].master) begin
        run_master($sformatf("v%0d", i), 1'b0, 8'h00, vec[i].exp_out);
      end else begin
        slave_bits(vec[i].din, 8, bits, rdy);
        check($sformatf("v%0d_out_bits", i), {24'd0, bits}, {24'd0, vec[i].exp_out});
        check($sformatf("v%0d_ready_first", i), {31'd0, rdy}, 32'd1);
      end
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
    end

    // tx_valid in the same cycle as the byte load: current byte is the open-line value.
    master_mode = 1'b1; loop = 1'b1;
    sb_q.push_back(8'hFF);
    run_master("coinc_first", 1'b1, 8'h33, 8'hFF);
    check("coinc_tx_ready", {31'd0, tx_ready}, 32'd0);
    sb_q.push_back(8'h33);
    run_master("coinc_next", 1'b0, 8'h00, 8'h33);
    check("coinc_ready_after", {31'd0, tx_ready}, 32'd1);

    // Asynchronous reset after three bits of a master transfer.
    queue_tx(8'hAA);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000 && cnt < 3; i++) begin
      @(negedge clk);
      if (serial_clk_out && busy) begin
        cnt++;
        while (serial_clk_out && cnt < 3) @(negedge clk);
      end
    end
    check("rstmid_bits_seen", cnt, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rstmid_sclk_out", {31'd0, serial_clk_out}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_rx_valid", {31'd0, rx_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    queue_tx(8'h3C);
    sb_q.push_back(8'h3C);
    run_master("rstmid_next", 1'b0, 8'h00, 8'h3C);

    // Slave transfer stalled after four bits.
    #1 master_mode = 1'b0; loop = 1'b0;
    repeat (2) @(posedge clk);
    slave_bits(8'hF0, 4, bits, rdy);
    check("stall_out_bits", {28'd0, bits[3:0]}, 32'hF);
    pulses = 0; first = 0;
`ifdef LINK_TIMEOUT_EN
    for (int i = 7; i <= 300; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check("to_pulses", pulses, 32'd1);
    check("to_latency_ok", {31'd0, (first >= TO) && (first <= TO + 6)}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_tx_ready", {31'd0, tx_ready}, 32'd1);
`else
    for (int i = 7; i <= 300; i++) begin
      @(negedge clk);
      if (timeout_err) pulses++;
    end
    check("stall_no_timeout", pulses, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check("stall_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
`endif
    repeat (10) @(negedge clk);
    check("rx_count", rx_count, 32'd9);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
